// File: rtl/data_mem_lsu.sv
// Load/store unit between the single-cycle core and a valid/ready data-memory bus.
// Drives byte strobes and lane-replicated store data; aligns and extends load data; stalls the core until the access completes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no access; a legal request stalls the core and is latched
// S_REQ  | DREQ_VALID high, request held until DREQ_READY
// S_WAIT | request accepted, waiting for DRSP_VALID or timeout
// S_DONE | one cycle, core commits; LSU_ERR pulses if the access failed
module data_mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] mem_read,
    output logic        lsu_err,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic        dreq_we,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_wstrb,
    output logic [31:0] dreq_wdata,
    input  logic        drsp_valid,
    input  logic [31:0] drsp_rdata,
    input  logic        drsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // WAIT counts from 0 on entry, so the last allowed WAIT cycle sees TIMEOUT-1.
    localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        err_q;

    logic        req_any;
    logic        f3_ok;
    logic        aligned;
    logic        legal;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        req_any = mem_rd | mem_wr;

        f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = mem_rd;
            default:                f3_ok = 1'b0;
        endcase

        aligned = 1'b0;
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase

        legal = (mem_rd ^ mem_wr) & f3_ok & aligned;

        strb_d  = 4'b1111;
        wdata_d = wdata;
        case (funct3[1:0])
            2'b00: begin
                strb_d  = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                strb_d  = 4'b1111;
                wdata_d = wdata;
            end
        endcase
        if (!mem_wr) begin
            strb_d = 4'b0000;
        end
    end

    always_comb begin
        rd_byte  = drsp_rdata[{addr_lo_q, 3'b000} +: 8];
        rd_half  = drsp_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        load_ext = drsp_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'h000000, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'h0000, rd_half};
            default: load_ext = drsp_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (legal) begin
                        stall   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (dreq_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (drsp_valid || (cnt_q == CNT_TC)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dreq_valid = (state_q == S_REQ);
    assign lsu_err    = (state_q == S_DONE) & err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            err_q      <= 1'b0;
            mem_read   <= 32'h0;
            dreq_we    <= 1'b0;
            dreq_addr  <= 32'h0;
            dreq_wstrb <= 4'b0000;
            dreq_wdata <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        if (legal) begin
                            cnt_q      <= 8'd0;
                            addr_lo_q  <= addr[1:0];
                            funct3_q   <= funct3;
                            err_q      <= 1'b0;
                            dreq_we    <= mem_wr;
                            dreq_addr  <= {addr[31:2], 2'b00};
                            dreq_wstrb <= strb_d;
                            dreq_wdata <= wdata_d;
                        end else begin
                            err_q <= 1'b1;
                            if (mem_rd) begin
                                mem_read <= 32'h0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (drsp_valid) begin
                        err_q <= drsp_err;
                        if (!dreq_we) begin
                            mem_read <= drsp_err ? 32'h0 : load_ext;
                        end
                    end else if (cnt_q == CNT_TC) begin
                        err_q <= 1'b1;
                        if (!dreq_we) begin
                            mem_read <= 32'h0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a small bus responder drives each access,
// and each scenario task compares the recorded results against hand-computed values.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] mem_read;
    logic        lsu_err;
    logic        dreq_valid;
    logic        dreq_ready = 1'b0;
    logic        dreq_we;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_wstrb;
    logic [31:0] dreq_wdata;
    logic        drsp_valid = 1'b0;
    logic [31:0] drsp_rdata = 32'h0;
    logic        drsp_err = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Results recorded by do_access for the scenario tasks to check.
    logic        r_stall0;
    int          r_stall_cnt;
    int          r_done_k;
    int          r_accept_k;
    logic        r_req_seen;
    int          r_req_cycles;
    logic        r_stable;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_mem_read;

    data_mem_lsu #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .mem_read   (mem_read),
        .lsu_err    (lsu_err),
        .dreq_valid (dreq_valid),
        .dreq_ready (dreq_ready),
        .dreq_we    (dreq_we),
        .dreq_addr  (dreq_addr),
        .dreq_wstrb (dreq_wstrb),
        .dreq_wdata (dreq_wdata),
        .drsp_valid (drsp_valid),
        .drsp_rdata (drsp_rdata),
        .drsp_err   (drsp_err)
    );

    always #5 clk = ~clk;

    // Presents one instruction and plays the bus: READY after ready_delay REQ cycles,
    // response rsp_delay cycles into WAIT (-1 = never). noise drives a junk response during REQ.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ready_delay, input int rsp_delay,
                             input logic [31:0] rdata, input logic rerr, input logic noise);
        int   req_n;
        int   wait_n;
        logic accepted;
        logic responded;
        logic done;
        req_n = 0; wait_n = 0; accepted = 1'b0; responded = 1'b0; done = 1'b0;
        r_stall0 = 1'b0; r_stall_cnt = 0; r_done_k = -1; r_accept_k = -1;
        r_req_seen = 1'b0; r_req_cycles = 0; r_stable = 1'b1;
        r_we = 1'b0; r_addr = 32'h0; r_wstrb = 4'h0; r_wdata = 32'h0;
        r_err = 1'b0; r_mem_read = 32'h0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
            end
            dreq_ready = dreq_valid && (req_n >= ready_delay);
            drsp_valid = 1'b0; drsp_rdata = 32'h0; drsp_err = 1'b0;
            if (dreq_valid && noise) begin
                drsp_valid = 1'b1; drsp_rdata = 32'hDEADBEEF;
            end
            if (accepted && !responded) begin
                if (wait_n == rsp_delay) begin
                    drsp_valid = 1'b1; drsp_rdata = rdata; drsp_err = rerr;
                    responded = 1'b1;
                end
                wait_n++;
            end
            #1;
            if (k == 0) r_stall0 = stall;
            if (k >= 1 && !stall) begin
                done = 1'b1; r_done_k = k; r_err = lsu_err; r_mem_read = mem_read;
                mem_rd = 1'b0; mem_wr = 1'b0; drsp_valid = 1'b0; dreq_ready = 1'b0;
            end else begin
                if (stall) r_stall_cnt++;
                if (dreq_valid) begin
                    if (!r_req_seen) begin
                        r_we = dreq_we; r_addr = dreq_addr; r_wstrb = dreq_wstrb; r_wdata = dreq_wdata;
                    end else if (r_we !== dreq_we || r_addr !== dreq_addr ||
                                 r_wstrb !== dreq_wstrb || r_wdata !== dreq_wdata) begin
                        r_stable = 1'b0;
                    end
                    r_req_seen = 1'b1; r_req_cycles++; req_n++;
                    if (dreq_ready) begin
                        accepted = 1'b1; r_accept_k = k;
                    end
                end
            end
        end
        if (!done) begin
            n_assert++; n_fail++;
            $display("FAIL access_bound: no DONE within 64 cycles (stall=%b) required DONE", stall);
            mem_rd = 1'b0; mem_wr = 1'b0; drsp_valid = 1'b0; dreq_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_assert++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
        n_assert++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dreq_valid: got %b required 0", dreq_valid); end
        n_assert++; if (dreq_addr !== 32'h0) begin n_fail++; $display("FAIL reset_dreq_addr: got %h required 0", dreq_addr); end
        n_assert++; if (dreq_wstrb !== 4'h0 || dreq_we !== 1'b0) begin n_fail++; $display("FAIL reset_wstrb_we: got %b/%b required 0000/0", dreq_wstrb, dreq_we); end
        n_assert++; if (dreq_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dreq_wdata: got %h required 0", dreq_wdata); end
        n_assert++; if (mem_read !== 32'h0 || lsu_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read_err: got %h/%b required 0/0", mem_read, lsu_err); end
        rstn = 1'b1;
    endtask

    task automatic test_load_byte();
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 1'b0);
        n_assert++; if (r_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_dreq_addr: got %h required 00001000", r_addr); end
        n_assert++; if (r_wstrb !== 4'b0000 || r_we !== 1'b0) begin n_fail++; $display("FAIL lb_wstrb_we: got %b/%b required 0000/0", r_wstrb, r_we); end
        n_assert++; if (r_mem_read !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_mem_read: got %h required ffffff80", r_mem_read); end
        n_assert++; if (r_stall_cnt !== 3 || r_done_k !== 3) begin n_fail++; $display("FAIL lb_latency: stall %0d done %0d required 3/3", r_stall_cnt, r_done_k); end
        n_assert++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b required 0", r_err); end
    endtask

    task automatic test_load_half();
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_0000, 1'b0, 1'b0);
        n_assert++; if (r_mem_read !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_mem_read: got %h required 0000beef", r_mem_read); end
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_0000, 1'b0, 1'b0);
        n_assert++; if (r_mem_read !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh_mem_read: got %h required ffffbeef", r_mem_read); end
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_1001, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 1'b0);
        n_assert++; if (r_mem_read !== 32'h0000_0022) begin n_fail++; $display("FAIL lbu_mem_read: got %h required 00000022", r_mem_read); end
        // junk DRSP_VALID during REQ and the accept cycle must not be captured
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 1, 0, 32'h89AB_CDEF, 1'b0, 1'b1);
        n_assert++; if (r_mem_read !== 32'h89AB_CDEF || r_done_k !== 4) begin n_fail++; $display("FAIL lw_early_rsp: got %h done %0d required 89abcdef done 4", r_mem_read, r_done_k); end
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_assert++; if (r_we !== 1'b1 || r_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_we_wstrb: got %b/%b required 1/1100", r_we, r_wstrb); end
        n_assert++; if (r_wdata !== 32'hABCD_ABCD || r_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_wdata_addr: got %h/%h required abcdabcd/00002000", r_wdata, r_addr); end
        n_assert++; if (r_mem_read !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL sh_mem_read_held: got %h required 89abcdef", r_mem_read); end
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_assert++; if (r_wstrb !== 4'b0010 || r_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_lanes: got %b/%h required 0010/a5a5a5a5", r_wstrb, r_wdata); end
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_assert++; if (r_wstrb !== 4'b1111 || r_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_lanes: got %b/%h required 1111/cafef00d", r_wstrb, r_wdata); end
        n_assert++; if (r_mem_read !== 32'h89AB_CDEF || r_err !== 1'b0) begin n_fail++; $display("FAIL sw_mem_read_err: got %h/%b required 89abcdef/0", r_mem_read, r_err); end
    endtask

    task automatic test_illegal();
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        n_assert++; if (r_stall0 !== 1'b0 || r_req_seen !== 1'b0) begin n_fail++; $display("FAIL lw_mis_no_req: stall %b req %b required 0/0", r_stall0, r_req_seen); end
        n_assert++; if (r_done_k !== 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL lw_mis_err: done %0d err %b required 1/1", r_done_k, r_err); end
        n_assert++; if (r_mem_read !== 32'h0) begin n_fail++; $display("FAIL lw_mis_mem_read: got %h required 0", r_mem_read); end
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_1003, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        n_assert++; if (r_err !== 1'b1 || r_req_seen !== 1'b0) begin n_fail++; $display("FAIL lh_mis: err %b req %b required 1/0", r_err, r_req_seen); end
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'h0, 0, 0, 32'h0000_007F, 1'b0, 1'b0);
        n_assert++; if (r_mem_read !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos: got %h required 0000007f", r_mem_read); end
        do_access(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        n_assert++; if (r_err !== 1'b1 || r_req_seen !== 1'b0 || r_mem_read !== 32'h0000_007F) begin n_fail++; $display("FAIL store_f3_illegal: err %b req %b mem_read %h required 1/0/0000007f", r_err, r_req_seen, r_mem_read); end
        do_access(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        n_assert++; if (r_err !== 1'b1 || r_req_seen !== 1'b0 || r_stall0 !== 1'b0) begin n_fail++; $display("FAIL rd_and_wr: err %b req %b stall %b required 1/0/0", r_err, r_req_seen, r_stall0); end
        do_access(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        n_assert++; if (r_err !== 1'b1 || r_req_seen !== 1'b0) begin n_fail++; $display("FAIL load_f3_illegal: err %b req %b required 1/0", r_err, r_req_seen); end
    endtask

    task automatic test_ready_stall();
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 3, 0, 32'h55AA_55AA, 1'b0, 1'b0);
        n_assert++; if (r_req_cycles !== 4 || r_stable !== 1'b1) begin n_fail++; $display("FAIL ready_hold: req cycles %0d stable %b required 4/1", r_req_cycles, r_stable); end
        n_assert++; if (r_addr !== 32'h0000_4000) begin n_fail++; $display("FAIL ready_addr: got %h required 00004000", r_addr); end
        n_assert++; if (r_stall_cnt !== 6 || r_done_k !== 6) begin n_fail++; $display("FAIL ready_stall: stall %0d done %0d required 6/6", r_stall_cnt, r_done_k); end
        n_assert++; if (r_mem_read !== 32'h55AA_55AA) begin n_fail++; $display("FAIL ready_mem_read: got %h required 55aa55aa", r_mem_read); end
    endtask

    task automatic test_bus_err();
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'h0, 0, 2, 32'h7FFF_0000, 1'b1, 1'b0);
        n_assert++; if (r_err !== 1'b1 || r_mem_read !== 32'h0) begin n_fail++; $display("FAIL bus_err: err %b mem_read %h required 1/0", r_err, r_mem_read); end
        n_assert++; if (r_done_k !== 5) begin n_fail++; $display("FAIL bus_err_latency: done %0d required 5", r_done_k); end
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_6001, 32'h0, 0, 5, 32'h0000_9900, 1'b0, 1'b0);
        n_assert++; if (r_err !== 1'b0 || r_mem_read !== 32'h0000_0099) begin n_fail++; $display("FAIL late_rsp: err %b mem_read %h required 0/00000099", r_err, r_mem_read); end
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 0, -1, 32'h0, 1'b0, 1'b0);
        // DONE begins 8 clock edges after the edge that accepted the request
        n_assert++; if (r_done_k - r_accept_k !== 9) begin n_fail++; $display("FAIL timeout_latency: done-accept %0d required 9", r_done_k - r_accept_k); end
        n_assert++; if (r_err !== 1'b1 || r_mem_read !== 32'h0) begin n_fail++; $display("FAIL timeout_err: err %b mem_read %h required 1/0", r_err, r_mem_read); end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_7000, 32'h0, 0, 0, 32'h0000_00F0, 1'b0, 1'b0);
        n_assert++; if (r_mem_read !== 32'h0000_00F0 || r_done_k !== 3) begin n_fail++; $display("FAIL b2b_first: %h done %0d required 000000f0/3", r_mem_read, r_done_k); end
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_7002, 32'h0, 0, 0, 32'h8001_0000, 1'b0, 1'b0);
        n_assert++; if (r_mem_read !== 32'h0000_8001 || r_done_k !== 3) begin n_fail++; $display("FAIL b2b_second: %h done %0d required 00008001/3", r_mem_read, r_done_k); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000; dreq_ready = 1'b1;
        @(negedge clk);
        #1;
        n_assert++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rst_wait_req: dreq_valid %b required 1", dreq_valid); end
        @(negedge clk);
        dreq_ready = 1'b0; mem_rd = 1'b0; rstn = 1'b0;
        #1;
        n_assert++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_wait_stall: got %b required 1", stall); end
        @(negedge clk);
        rstn = 1'b1; drsp_valid = 1'b1; drsp_rdata = 32'h1234_5678;
        #1;
        n_assert++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || dreq_addr !== 32'h0) begin n_fail++; $display("FAIL rst_wait_outputs: stall %b valid %b addr %h required 0/0/0", stall, dreq_valid, dreq_addr); end
        @(negedge clk);
        drsp_valid = 1'b0; drsp_rdata = 32'h0;
        #1;
        n_assert++; if (mem_read !== 32'h0 || lsu_err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_wait_late_rsp: mem_read %h err %b stall %b required 0/0/0", mem_read, lsu_err, stall); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store();
        test_illegal();
        test_ready_stall();
        test_bus_err();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
